fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- N_REQ, default 4: number of producers.
- DW, default 4: data width.
- STALL_MAX, default 15: blocked-cycle limit before the stall error.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_vld  in  N_REQ  per-producer write request.
- req_data  in  N_REQ*DW  producer data; slice i is bits [i*DW +: DW].
- req_rdy  out  N_REQ  per-producer accept, one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_read_en  in  1  FIFO read in this cycle; permits a write while full.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_write_data  out  DW  FIFO write data.
- gnt_id  out  $clog2(N_REQ)  index of the granted producer; valid when fifo_write_en=1.
- arb_state  out  2  FSM state, for debug.
- stall_err  out  1  sticky starvation flag.

Function
REQ-003 A producer write SHALL complete in any cycle where req_vld[i] and req_rdy[i] are both 1.
- Producers hold req_vld and data stable until accepted.
REQ-004 can_wr SHALL be defined as !fifo_full || fifo_read_en.
REQ-005 Grant SHALL be combinational in the same cycle.
- When can_wr=1 and |req_vld=1: exactly one req_rdy bit is set.
- Otherwise req_rdy=0.
REQ-006 The winner SHALL be the first set req_vld bit searching upward from rr_ptr, with wrap-around from N_REQ-1 to 0.
REQ-007 On a grant to producer k, rr_ptr SHALL become (k+1) mod N_REQ at the next edge; otherwise rr_ptr holds.
REQ-008 While a grant exists, fifo_write_en SHALL be 1, fifo_write_data SHALL equal req_data slice k, and gnt_id SHALL equal k.
- Without a grant: fifo_write_en=0 and fifo_write_data=0.
REQ-009 Fairness: a continuously requesting producer SHALL be granted within N_REQ-1 granted cycles of other producers.
REQ-010 The FSM SHALL have three states, encoded in arb_state as IDLE=0, ACTIVE=1, BLOCKED=2.
REQ-011 The FSM next state SHALL be decided each cycle as follows:
- Next state is IDLE if |req_vld=0.
- Next state is ACTIVE if a grant occurs.
- Next state is BLOCKED if |req_vld=1 and can_wr=0.
REQ-012 stall_cnt (width $clog2(STALL_MAX+1)) SHALL increment in each BLOCKED-bound cycle, saturate at STALL_MAX, and clear on any grant or in IDLE.
REQ-013 stall_err SHALL set on the edge where stall_cnt reaches STALL_MAX and remain set until reset.
REQ-014 fifo_full=1 together with fifo_read_en=1 SHALL still produce a grant, so that a simultaneous read and write is allowed.
REQ-015 A producer deasserting req_vld before acceptance SHALL be legal; the block SHALL neither record it nor grant it.

Reset
REQ-016 While rst_b=0, the block SHALL hold: rr_ptr=0, state=IDLE, stall_cnt=0, stall_err=0.
- Combinational outputs follow from these values and the inputs.
REQ-017 Reset asserted mid-operation SHALL abort the current cycle's grant.
- The first cycle after release arbitrates from producer 0.

Configuration
REQ-018 With FIFO_ARB_STATS_EN defined, the block SHALL add output gnt_cnt, width N_REQ*8.
- One 8-bit wrapping counter per producer, incremented on each grant to that producer.
- All counters are 0 on reset.
REQ-019 Without FIFO_ARB_STATS_EN, the port and the counters SHALL be absent; all other behaviour is identical.

Structure
REQ-020 Package fifo_arb_pkg SHALL hold:
- arb_state_e (IDLE, ACTIVE, BLOCKED);
- default constants N_REQ_DEF=4, DW_DEF=4, STALL_MAX_DEF=15.
REQ-021 Sub-module rr_pick SHALL implement the combinational round-robin search.
- Inputs: req vector and pointer.
- Outputs: one-hot grant and index.
- fifo_wr_arbiter instantiates it once.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- After reset, req_vld=4'b1111, fifo_full=0 for 4 cycles -> gnt_id sequence 0,1,2,3; fifo_write_data matches each slice.
- rr_ptr=2, req_vld=4'b0011 -> grant to 0, then to 1; rr_ptr wraps.
- fifo_full=1, fifo_read_en=0, req_vld=4'b0100 -> req_rdy=0, arb_state=BLOCKED; stall_err=1 after the 15th blocked cycle and stays 1 after the full condition clears.
- fifo_full=1, fifo_read_en=1, req_vld=4'b1000 -> fifo_write_en=1, gnt_id=3 in the same cycle.
- rst_b pulsed low while arb_state=ACTIVE, rr_ptr=3 -> req_rdy=0 during reset; first grant after release goes to the lowest requesting producer.
- With FIFO_ARB_STATS_EN: 300 grants to producer 1 -> gnt_cnt slice 1 = 44 (wrapped); other slices 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 4;
  localparam int STALL_MAX_DEF = 15;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set req bit at or above ptr, wrapping past N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick becomes a grant.
// Ports: req (request vector), ptr (search start), gnt (one-hot pick or 0), idx (index of pick).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] jj;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    gnt   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling N_REQ producers into one FIFO write port.
// Latency: grant, write strobe and data are combinational in the request cycle.
// Backpressure: no grant while the FIFO is full unless it is also read this cycle.
// Ports: clk/rst_b; req_vld/req_data/req_rdy producer handshake; fifo_full/fifo_read_en
//   FIFO status; fifo_write_en/fifo_write_data/gnt_id FIFO write side; arb_state and
//   stall_err for debug. Define FIFO_ARB_STATS_EN to add gnt_cnt (8-bit grant count per producer).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         req_rdy,
  input  logic                     fifo_full,
  input  logic                     fifo_read_en,
  output logic                     fifo_write_en,
  output logic [DW-1:0]            fifo_write_data,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [1:0]               arb_state,
  output logic                     stall_err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*8-1:0]       gnt_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_MAX_V = SW'(STALL_MAX);

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [SW-1:0]   stall_cnt, stall_cnt_nxt;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            can_wr, any_req, grant;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // A simultaneous FIFO read frees the slot we are about to fill.
  assign can_wr  = !fifo_full || fifo_read_en;
  assign any_req = |req_vld;
  // Gating with rst_b drops any grant the instant reset asserts.
  assign grant   = rst_b && can_wr && any_req;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = BLOCKED;
    if (!any_req)   state_nxt = IDLE;
    else if (grant) state_nxt = ACTIVE;
  end

  // Output logic
  always_comb begin
    arb_state       = state;
    fifo_write_en   = grant;
    req_rdy         = grant ? pick_gnt : '0;
    gnt_id          = grant ? pick_idx : '0;
    fifo_write_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && pick_gnt[i]) fifo_write_data = fifo_write_data | req_data[i*DW +: DW];
    end
  end

  // Blocked-cycle counter: counts only cycles heading into BLOCKED, saturating.
  always_comb begin
    stall_cnt_nxt = '0;
    if (state_nxt == BLOCKED)
      stall_cnt_nxt = (stall_cnt == STALL_MAX_V) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == STALL_MAX_V) stall_err <= 1'b1;
      // Pointer moves just past the winner so it becomes lowest priority next round.
      if (grant) rr_ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant && pick_gnt[i]) gnt_cnt[i*8 +: 8] <= gnt_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
